// File: rtl/dispatch.sv
// rtl/dispatch.sv - two-wide decode-to-issue-queue staging FIFO with back-pressure stall counter
module dispatch #(
    parameter int DEPTH     = 4,
    parameter int ELEM_W    = 32,
    parameter int IQ_ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [1:0][ELEM_W-1:0] dec_data,
    input  logic [1:0]             dec_number,
    output logic                   dec_ready,
    input  logic [IQ_ADDR_W-1:0]   iq_size_left,
    output logic [1:0][ELEM_W-1:0] iq_in_data,
    output logic [1:0]             iq_in_number,
    output logic [15:0]            stall_cycles
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ELEM_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic [1:0] accept_n;
    logic [1:0] avail;
    logic [1:0] limit;
    logic [1:0] pop_raw;
    logic [1:0] pop_n;
    logic       stall_inc;

    // Ready depends only on registered occupancy so upstream never sees a comb loop.
    assign dec_ready = (count <= CNT_W'(DEPTH - 2));

    always_comb begin
        accept_n = 2'd0;
        if (dec_ready && !flush && dec_number != 2'd3) begin
            accept_n = dec_number;
        end
        avail     = (count >= CNT_W'(2)) ? 2'd2 : count[1:0];
        limit     = (iq_size_left >= IQ_ADDR_W'(2)) ? 2'd2 : iq_size_left[1:0];
        pop_raw   = (avail < limit) ? avail : limit;
        pop_n     = flush ? 2'd0 : pop_raw;
        stall_inc = !flush && (pop_raw < avail);
    end

    assign iq_in_number  = pop_n;
    assign iq_in_data[0] = mem[head];
    assign iq_in_data[1] = mem[head + PTR_W'(1)];

    always_ff @(posedge clk) begin
        if (accept_n != 2'd0) begin
            mem[tail] <= dec_data[0];
        end
        if (accept_n == 2'd2) begin
            mem[tail + PTR_W'(1)] <= dec_data[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            stall_cycles <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_n);
            tail  <= tail + PTR_W'(accept_n);
            count <= count + CNT_W'(accept_n) - CNT_W'(pop_n);
            if (stall_inc && stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_dispatch.sv
// tb/tb_dispatch.sv - randomized self-checking bench for dispatch against a queue model
module tb_dispatch;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [1:0][31:0] dec_data = '0;
    logic [1:0]       dec_number = 2'd0;
    logic             dec_ready;
    logic [3:0]       iq_size_left = 4'd0;
    logic [1:0][31:0] iq_in_data;
    logic [1:0]       iq_in_number;
    logic [15:0]      stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q[$];
    int          m_stall = 0;

    logic        obs_ready, exp_ready;
    logic [1:0]  obs_num, exp_num;
    logic [31:0] obs_d0, obs_d1, exp_d0, exp_d1;
    logic [15:0] obs_stall, exp_stall;

    dispatch #(.DEPTH(DEPTH), .ELEM_W(32), .IQ_ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dec_data(dec_data), .dec_number(dec_number), .dec_ready(dec_ready),
        .iq_size_left(iq_size_left), .iq_in_data(iq_in_data),
        .iq_in_number(iq_in_number), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic int min3(int a, int b, int c);
        int m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    // One clock: drive, sample at negedge with model expectations, then advance the model.
    task automatic cycle(input logic r, input logic f, input logic [1:0] n, input logic [3:0] sz);
        int p, avail, acc;
        bit rdy;
        rst = r; flush = f; dec_number = n; iq_size_left = sz;
        dec_data[0] = $urandom; dec_data[1] = $urandom;
        avail = (q.size() < 2) ? q.size() : 2;
        p = f ? 0 : min3(q.size(), 2, int'(sz));
        rdy = (DEPTH - q.size()) >= 2;
        exp_ready = rdy; exp_num = 2'(p); exp_stall = 16'(m_stall);
        exp_d0 = (q.size() > 0) ? q[0] : 32'h0;
        exp_d1 = (q.size() > 1) ? q[1] : 32'h0;
        @(negedge clk);
        obs_ready = dec_ready; obs_num = iq_in_number; obs_stall = stall_cycles;
        obs_d0 = iq_in_data[0]; obs_d1 = iq_in_data[1];
        @(posedge clk);
        if (r) begin
            q.delete(); m_stall = 0;
        end else if (f) begin
            q.delete();
        end else begin
            for (int i = 0; i < p; i++) void'(q.pop_front());
            if (p < avail && m_stall < 65535) m_stall++;
            acc = (rdy && n != 2'd3) ? int'(n) : 0;
            if (acc >= 1) q.push_back(dec_data[0]);
            if (acc == 2) q.push_back(dec_data[1]);
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 2'd0, 4'd0);
        cycle(0, 0, 2'd0, 4'd8);
        n_checks++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", obs_ready); end
        n_checks++; if (obs_num !== 2'd0) begin n_fail++; $display("FAIL reset_num got %0d want 0", obs_num); end
        n_checks++; if (obs_stall !== 16'd0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", obs_stall); end
    endtask

    task automatic test_stream();
        logic [31:0] sent[$];
        logic [31:0] got[$];
        cycle(1, 0, 2'd0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 2'd2, 4'd8);
            sent.push_back(dec_data[0]); sent.push_back(dec_data[1]);
            if (obs_num >= 1) got.push_back(obs_d0);
            if (obs_num == 2) got.push_back(obs_d1);
            if (i >= 1) begin
                n_checks++; if (obs_num !== 2'd2) begin n_fail++; $display("FAIL stream_num cyc %0d got %0d want 2", i, obs_num); end
            end
            n_checks++; if (obs_stall !== 16'd0) begin n_fail++; $display("FAIL stream_stall got %0d want 0", obs_stall); end
        end
        for (int i = 0; i < got.size(); i++) begin
            n_checks++; if (got[i] !== sent[i]) begin n_fail++; $display("FAIL stream_order idx %0d got %h want %h", i, got[i], sent[i]); end
        end
    endtask

    task automatic test_back_pressure();
        logic [15:0] s0;
        cycle(1, 0, 2'd0, 4'd0);
        cycle(0, 0, 2'd2, 4'd0);
        cycle(0, 0, 2'd2, 4'd0);
        cycle(0, 0, 2'd0, 4'd0);
        s0 = obs_stall;
        cycle(0, 0, 2'd2, 4'd0);
        n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready got %b want 0", obs_ready); end
        n_checks++; if (obs_num !== 2'd0) begin n_fail++; $display("FAIL bp_num got %0d want 0", obs_num); end
        cycle(0, 0, 2'd0, 4'd0);
        cycle(0, 0, 2'd0, 4'd1);
        n_checks++; if (obs_stall !== s0 + 16'd3) begin n_fail++; $display("FAIL bp_stall got %0d want %0d", obs_stall, s0 + 16'd3); end
        n_checks++; if (obs_stall !== exp_stall) begin n_fail++; $display("FAIL bp_stall_model got %0d want %0d", obs_stall, exp_stall); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (obs_num !== 2'd1 || obs_d0 !== exp_d0) begin n_fail++; $display("FAIL bp_single got %0d/%h want 1/%h", obs_num, obs_d0, exp_d0); end
            cycle(0, 0, 2'd0, 4'd1);
        end
        n_checks++; if (obs_num !== 2'd1 || obs_d0 !== exp_d0) begin n_fail++; $display("FAIL bp_single_last got %0d/%h want 1/%h", obs_num, obs_d0, exp_d0); end
    endtask

    task automatic test_odd_widths();
        logic [31:0] sent[$];
        logic [31:0] got[$];
        logic [1:0]  seq[3] = '{2'd1, 2'd2, 2'd1};
        cycle(1, 0, 2'd0, 4'd0);
        cycle(0, 0, 2'd1, 4'd8);  // offset the pointers so the sequence wraps
        cycle(0, 0, 2'd0, 4'd8);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, (i < 3) ? seq[i] : 2'd0, 4'd8);
            if (i < 3) begin
                sent.push_back(dec_data[0]);
                if (seq[i] == 2'd2) sent.push_back(dec_data[1]);
            end
            if (obs_num >= 1) got.push_back(obs_d0);
            if (obs_num == 2) got.push_back(obs_d1);
        end
        n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL odd_count got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== sent[i]) begin n_fail++; $display("FAIL odd_order idx %0d got %h want %h", i, got[i], sent[i]); end
        end
        n_checks++; if (obs_num !== 2'd0 || obs_ready !== 1'b1) begin n_fail++; $display("FAIL odd_empty got num %0d rdy %b want 0 1", obs_num, obs_ready); end
    endtask

    task automatic test_flush();
        logic [15:0] s0;
        cycle(1, 0, 2'd0, 4'd0);
        cycle(0, 0, 2'd2, 4'd0);
        cycle(0, 0, 2'd1, 4'd0);
        cycle(0, 1, 2'd2, 4'd8);
        s0 = obs_stall;
        n_checks++; if (obs_num !== 2'd0) begin n_fail++; $display("FAIL flush_num got %0d want 0", obs_num); end
        cycle(0, 0, 2'd0, 4'd8);
        n_checks++; if (obs_num !== 2'd0) begin n_fail++; $display("FAIL flush_after_num got %0d want 0", obs_num); end
        n_checks++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", obs_ready); end
        n_checks++; if (obs_stall !== s0) begin n_fail++; $display("FAIL flush_stall got %0d want %0d", obs_stall, s0); end
    endtask

    task automatic test_random();
        cycle(1, 0, 2'd0, 4'd0);
        for (int i = 0; i < 400; i++) begin
            cycle(0, ($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
            n_checks++;
            if (obs_ready !== exp_ready || obs_num !== exp_num || obs_stall !== exp_stall ||
                (exp_num >= 1 && obs_d0 !== exp_d0) || (exp_num == 2 && obs_d1 !== exp_d1)) begin
                n_fail++;
                $display("FAIL random cyc %0d got rdy %b n %0d st %0d d %h %h want rdy %b n %0d st %0d d %h %h",
                         i, obs_ready, obs_num, obs_stall, obs_d0, obs_d1, exp_ready, exp_num, exp_stall, exp_d0, exp_d1);
            end
        end
    endtask

    task automatic test_saturation();
        cycle(1, 0, 2'd0, 4'd0);
        cycle(0, 0, 2'd2, 4'd0);
        for (int i = 0; i < 65540; i++) cycle(0, 0, 2'd0, 4'd0);
        cycle(0, 0, 2'd0, 4'd0);
        n_checks++; if (obs_stall !== 16'hFFFF) begin n_fail++; $display("FAIL sat_stall got %h want ffff", obs_stall); end
    endtask

    task automatic test_mid_reset();
        cycle(1, 0, 2'd0, 4'd0);
        cycle(0, 0, 2'd2, 4'd0);
        cycle(0, 0, 2'd2, 4'd0);
        cycle(0, 0, 2'd2, 4'd0);
        n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", obs_ready); end
        cycle(1, 0, 2'd2, 4'd8);
        cycle(0, 0, 2'd0, 4'd8);
        n_checks++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL mreset_ready got %b want 1", obs_ready); end
        n_checks++; if (obs_num !== 2'd0) begin n_fail++; $display("FAIL mreset_num got %0d want 0", obs_num); end
        n_checks++; if (obs_stall !== 16'd0) begin n_fail++; $display("FAIL mreset_stall got %0d want 0", obs_stall); end
    endtask

    initial begin
        #1;
        test_reset();
        test_stream();
        test_back_pressure();
        test_odd_widths();
        test_flush();
        test_random();
        test_saturation();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dispatch.md
DISPATCH -- requirements
Module: dispatch

Interface
REQ-001 Parameter DEPTH, default 4, staging-buffer entries; power of two, at least 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  discard all buffered instructions (branch/exception redirect).
REQ-005 dec_data  input  ISSUE_QUEUE_ELEMENT[1:0]  decoded instructions; lane 0 is program-order older.
REQ-006 dec_number  input  2  number of valid decode lanes: 0, 1 (lane 0 only) or 2; value 3 is illegal and treated as 0.
REQ-007 dec_ready  output  1  buffer can accept two instructions this cycle.
REQ-008 iq_size_left  input  IQ_ADDR  free entries reported by issue_queue.
REQ-009 iq_in_data  output  ISSUE_QUEUE_ELEMENT[1:0]  instructions pushed to issue_queue; lane 0 older.
REQ-010 iq_in_number  output  2  number of valid iq_in_data lanes pushed this cycle (0..2).
REQ-011 stall_cycles  output  16  count of cycles dispatch was throttled by issue_queue back-pressure.

Function
REQ-012 Storage: circular FIFO of DEPTH ISSUE_QUEUE_ELEMENT entries; head pointer, tail pointer, occupancy count (0..DEPTH); pointers wrap modulo DEPTH.
REQ-013 dec_ready = 1 iff (DEPTH - count) >= 2; combinational from registered count only, with no path from iq_size_left or dec_* inputs.
REQ-014 Accept: when dec_ready = 1 and flush = 0, write dec_number entries at tail, lane 0 at tail and lane 1 at tail+1; tail advances by dec_number.
REQ-015 When dec_ready = 0, dec_data and dec_number are ignored and the upstream stage holds them.
REQ-016 Pop count P = min(count, 2, iq_size_left); combinational.
REQ-017 iq_in_number = P; iq_in_data[0] = entry[head], iq_in_data[1] = entry[head+1 mod DEPTH]; lanes at or above P are don't-care.
REQ-018 Head advances by P each cycle; issue_queue takes the pushed entries in that same cycle.
REQ-019 Occupancy: count_next = count + accepted - P; simultaneous accept and pop in one cycle is legal.
REQ-020 Latency: an instruction accepted in cycle N is presentable on iq_in_data in cycle N+1 at the earliest; there is no bypass from dec_data to iq_in_data.
REQ-021 Ordering: strict program order is preserved; an older instruction is never pushed after a younger one.
REQ-022 Flush: iq_in_number = 0 in the flush cycle, and decode input that cycle is discarded.
REQ-023 Flush: on the following edge, head, tail and count become 0 and stall_cycles is unchanged.
REQ-024 Flush and rst asserted together: rst takes precedence.
REQ-025 Stall: stall_cycles increments when flush = 0 and P < min(count, 2); saturates at 16'hFFFF.
REQ-026 Full: at count = DEPTH, dec_ready = 0 and popping proceeds normally.
REQ-027 Empty: at count = 0, iq_in_number = 0 regardless of iq_size_left, and stall_cycles does not increment.
REQ-028 iq_size_left of 0 or 1 limits P to that value; the remaining head entry is retained.

Reset
REQ-029 On rst = 1 at a rising edge: head = 0, tail = 0, count = 0, stall_cycles = 0, and buffer contents are don't-care.
REQ-030 In the cycle after reset: dec_ready = 1, iq_in_number = 0, stall_cycles = 0.
REQ-031 Reset asserted mid-operation discards all buffered and incoming instructions, with no partial push to issue_queue on the next cycle.

Verification
REQ-032 Stream: dec_number = 2 every cycle, iq_size_left = 8 -> from cycle 2 onward iq_in_number = 2 each cycle, order A0,A1,B0,B1..., stall_cycles stays 0.
REQ-033 Back-pressure: fill 4 entries, then iq_size_left = 0 for 3 cycles -> dec_ready = 0, iq_in_number = 0, stall_cycles = 3; iq_size_left = 1 -> one entry pushed per cycle.
REQ-034 Odd widths: dec_number sequence 1,2,1 with iq_size_left = 8 -> four instructions pushed in order, count returns to 0, wrap-around past entry DEPTH-1 exercised.
REQ-035 Flush: 3 buffered entries, flush = 1 with dec_number = 2 -> iq_in_number = 0 that cycle; next cycle count = 0, dec_ready = 1, nothing pushed.
REQ-036 Saturation: hold count = 2 and iq_size_left = 0 for 65540 cycles -> stall_cycles = 16'hFFFF and does not wrap.
REQ-037 Mid-operation reset: rst = 1 while full -> next cycle dec_ready = 1, iq_in_number = 0, stall_cycles = 0.
